mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 2, number of cache requesters (2..8).
REQ-002 SHALL have parameter AW, default 32, address width.
REQ-003 SHALL have parameter DW, default 32, data width.
REQ-004 SHALL have parameter TIMEOUT, default 255, max cycles one grant waits for ACCESS (1..1023).
REQ-005 SHALL have port CLK, input, 1, the single clock.
REQ-006 SHALL have port nRST, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port req_REN, input, NREQ, per-requester read request.
REQ-008 SHALL have port req_WEN, input, NREQ, per-requester write request.
REQ-009 SHALL have port req_addr, input, NREQ x AW, per-requester address.
REQ-010 SHALL have port req_store, input, NREQ x DW, per-requester write data.
REQ-011 SHALL have port req_wait, output, NREQ, per-requester stall (1 = not done).
REQ-012 SHALL have port req_err, output, NREQ, per-requester one-cycle error pulse.
REQ-013 SHALL have port req_load, output, DW, read data broadcast to all requesters.
REQ-014 SHALL have ports ramaddr (output, AW), ramstore (output, DW), ramREN (output, 1) and ramWEN (output, 1), the RAM-side request.
REQ-015 SHALL have ports ramload (input, DW) and ramstate (input, 2; FREE=0, BUSY=1, ACCESS=2, ERROR=3), the RAM-side response.
REQ-016 SHALL have ports gnt_id (output, clog2(NREQ)) and gnt_valid (output, 1), giving the current owner.

Function
REQ-017 SHALL implement FSM states IDLE and OWN; a requester is active when req_REN[i] or req_WEN[i] is 1.
REQ-018 In IDLE with any requester active, SHALL select the first active index at or after rr_ptr (mod NREQ), register it into gnt_id, and enter OWN on the next edge.
REQ-019 In IDLE, SHALL hold ramREN=ramWEN=0 and gnt_valid=0.
REQ-020 In OWN, SHALL set gnt_valid=1 and drive ramaddr and ramstore combinationally from requester gnt_id.
REQ-021 In OWN, SHALL drive ramWEN=req_WEN[gnt_id] and ramREN=req_REN[gnt_id] AND NOT req_WEN[gnt_id] (write wins).
REQ-022 req_load SHALL equal ramload in every cycle.
REQ-023 req_wait[i] SHALL be 0 only when i is inactive, or when state=OWN, gnt_id=i and ramstate is ACCESS or ERROR; otherwise 1.
REQ-024 In OWN with ramstate=ACCESS, SHALL set rr_ptr to (gnt_id+1) mod NREQ and return to IDLE, giving one idle bubble cycle between grants.
REQ-025 In OWN with ramstate=ERROR, SHALL pulse req_err[gnt_id] for that cycle, advance rr_ptr as on ACCESS, and return to IDLE.
REQ-026 In OWN, if requester gnt_id goes inactive before ACCESS, SHALL drop ramREN/ramWEN in that cycle, return to IDLE, leave rr_ptr unchanged and raise no error.
REQ-027 SHALL count consecutive OWN cycles without ACCESS/ERROR in a 10-bit counter that clears on entering OWN.
REQ-028 When the counter reaches TIMEOUT, SHALL pulse req_err[gnt_id] and set req_wait[gnt_id]=0 for that cycle, drop the RAM request, advance rr_ptr, and return to IDLE.
REQ-029 If ACCESS coincides with the timeout cycle, SHALL treat it as ACCESS with no error.
REQ-030 rr_ptr SHALL wrap from NREQ-1 to 0; with one active requester, that requester is granted on every arbitration.
REQ-031 A requester whose req_addr/req_store changes while it owns the bus SHALL have the new value forwarded the same cycle; no data latching.

Reset
REQ-032 While nRST=0, SHALL asynchronously force state=IDLE, rr_ptr=0, gnt_id=0 and the timeout counter to 0.
REQ-033 During reset, outputs SHALL be gnt_valid=0, ramREN=ramWEN=0, ramaddr=0, ramstore=0 and req_err=0, with req_wait following REQ-023.
REQ-034 Reset asserted mid-transaction SHALL abandon the transaction with no error pulse; after release, arbitration restarts from index 0.

Verification
REQ-035 Scenario: NREQ=2, req0 read 0x100, RAM returns ACCESS after 3 BUSY cycles with ramload=0xDEADBEEF -> ramREN=1 with ramaddr=0x100 for 4 cycles, req_wait[0] falls for 1 cycle, req_load=0xDEADBEEF, rr_ptr=1.
REQ-036 Scenario: req0 and req1 both requesting continuously, with ACCESS on the first OWN cycle -> grants alternate 0,1,0,1 with one IDLE cycle between grants.
REQ-037 Scenario: req1 asserts REN and WEN together at addr 0x40 with store 0x55 -> ramWEN=1, ramREN=0, ramstore=0x55.
REQ-038 Scenario: TIMEOUT=4, ramstate held BUSY -> after 4 OWN cycles, req_err[gnt] pulses once, req_wait drops, the FSM returns to IDLE.
REQ-039 Scenario: ramstate=ERROR on the 2nd OWN cycle -> one req_err pulse, rr_ptr advances.
REQ-040 Scenario: nRST pulsed low for 1 cycle during OWN -> gnt_valid=0 immediately, no req_err, and the next grant goes to the lowest active index.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one RAM port among NREQ cache requesters.
// Each grant lasts until the RAM answers, reports an error, times out, or the owner withdraws.
module mem_arbiter #(
  parameter int NREQ    = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                           CLK,
  input  logic                           nRST,
  // A requester holds REN/WEN (with stable intent) while req_wait is 1; the
  // cycle req_wait reads 0 with REN/WEN high is the completion cycle, after
  // which the requester may drop or issue its next request.
  input  logic [NREQ-1:0]                req_REN,
  input  logic [NREQ-1:0]                req_WEN,
  input  logic [NREQ-1:0][AW-1:0]        req_addr,
  input  logic [NREQ-1:0][DW-1:0]        req_store,
  output logic [NREQ-1:0]                req_wait,
  output logic [NREQ-1:0]                req_err,
  output logic [DW-1:0]                  req_load,
  output logic [AW-1:0]                  ramaddr,
  output logic [DW-1:0]                  ramstore,
  output logic                           ramREN,
  output logic                           ramWEN,
  input  logic [DW-1:0]                  ramload,
  input  logic [1:0]                     ramstate,
  output logic [$clog2(NREQ)-1:0]        gnt_id,
  output logic                           gnt_valid,
  output logic                           dbg_state,
  output logic [$clog2(NREQ)-1:0]        dbg_rr_ptr
);

  localparam int IW = $clog2(NREQ);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] OWN  = 1'b1;

  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  localparam logic [9:0] TMO = 10'(TIMEOUT);

  logic [0:0]      state;
  logic [IW-1:0]   rr_ptr;
  logic [9:0]      tmo_cnt;

  logic [NREQ-1:0] active;
  logic            own;
  logic            g_active;
  logic            hit;
  logic            fault;
  logic            expire;
  logic            done;
  logic            sel_found;
  logic [IW-1:0]   sel_id;
  logic [IW-1:0]   next_ptr;

  function automatic int wrap_idx(input int base, input int k);
    int s;
    s = base + k;
    return (s >= NREQ) ? s - NREQ : s;
  endfunction

  assign active   = req_REN | req_WEN;
  assign own      = (state == OWN);
  assign g_active = active[gnt_id];
  assign hit      = own && g_active && (ramstate == RS_ACCESS);
  assign fault    = own && g_active && (ramstate == RS_ERROR);
  // A RAM answer on the expiry cycle takes precedence over the timeout.
  assign expire   = own && g_active && !hit && !fault && (tmo_cnt == TMO);
  assign done     = hit || fault || expire;
  assign next_ptr = (gnt_id == IW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;

  // Scan downward so the closest active index at or after rr_ptr wins.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = rr_ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (active[wrap_idx(int'(rr_ptr), k)]) begin
        sel_found = 1'b1;
        sel_id    = IW'(wrap_idx(int'(rr_ptr), k));
      end
    end
  end

  always_comb begin
    ramaddr  = '0;
    ramstore = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    req_err  = '0;
    req_wait = active;
    if (own) begin
      ramaddr  = req_addr[gnt_id];
      ramstore = req_store[gnt_id];
      if (g_active && !expire) begin
        ramWEN = req_WEN[gnt_id];
        ramREN = req_REN[gnt_id] & ~req_WEN[gnt_id];
      end
      if (done) req_wait[gnt_id] = 1'b0;
      if (fault || expire) req_err[gnt_id] = 1'b1;
    end
  end

  assign req_load   = ramload;
  assign gnt_valid  = own;
  assign dbg_state  = state;
  assign dbg_rr_ptr = rr_ptr;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      gnt_id  <= '0;
      tmo_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_found) begin
            gnt_id  <= sel_id;
            tmo_cnt <= '0;
            state   <= OWN;
          end
        end
        OWN: begin
          // A withdrawn owner releases the bus without moving the pointer.
          if (!g_active) begin
            state <= IDLE;
          end else if (done) begin
            rr_ptr <= next_ptr;
            state  <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 10'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
